// File: rtl/unidade_controle_rodadas_pkg.sv
// Shared definitions for the memory-game round controller: state encodings,
// default show/gap/timeout durations and the round timer width.
package unidade_controle_rodadas_pkg;

  localparam int TIMER_W       = 12;
  localparam int T_SHOW_DEF    = 1000;
  localparam int T_GAP_DEF     = 500;
  localparam int T_TIMEOUT_DEF = 3000;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    MOSTRA      = 4'h2,
    INTERVALO   = 4'h3,
    PROX_MOSTRA = 4'h4,
    ESPERA      = 4'h5,
    REGISTRA    = 4'h6,
    COMPARA     = 4'h7,
    PROX_JOGADA = 4'h8,
    PROX_RODADA = 4'h9,
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hB,
    FIM_TIMEOUT = 4'hC
  } estado_t;

  // The timer is loaded at the end of a state's first cycle and the state
  // leaves on the cycle it reads zero, so a span of t cycles loads t-2.
  function automatic logic [TIMER_W-1:0] carga(input int t);
    return TIMER_W'(t - 2);
  endfunction

endpackage

// File: rtl/unidade_controle_rodadas_temporizador_rodada.sv
// Loadable down-counter used for the show, gap and play-timeout spans.
// Saturates at zero; fim is high whenever the count is zero.
module temporizador_rodada
  import unidade_controle_rodadas_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               enable,
  input  logic [TIMER_W-1:0] valor,
  output logic               fim
);

  logic [TIMER_W-1:0] contagem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      contagem <= '0;
    end else if (load) begin
      contagem <= valor;
    end else if (enable && contagem != '0) begin
      contagem <= contagem - TIMER_W'(1);
    end
  end

  assign fim = (contagem == '0);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore controller for the memory game: shows the sequence, checks plays and
// declares win/loss. Define TIMEOUT_EN to bound ESPERA by T_TIMEOUT cycles.
module unidade_controle_rodadas
  import unidade_controle_rodadas_pkg::*;
#(
  parameter int T_SHOW    = T_SHOW_DEF,
  parameter int T_GAP     = T_GAP_DEF,
  parameter int T_TIMEOUT = T_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       jogar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fim_contagem,
  input  logic       fim_rodadas,
  output logic       zera_contagem,
  output logic       conta_contagem,
  output logic       zera_limite,
  output logic       conta_limite,
  output logic       registra,
  output logic       leds_en,
  output logic       pronto,
  output logic       ganhou,
  output logic       perdeu,
  output logic       timeout,
  output logic [3:0] db_estado
);

  estado_t            estado, prox;
  logic               carrega;
  logic               fim_timer;
  logic               expirou;
  logic               conta_tempo;
  logic [TIMER_W-1:0] valor_carga;

  // carrega marks the first cycle of a state, when the count is still stale.
  assign expirou     = fim_timer && !carrega;
  assign conta_tempo = estado inside {MOSTRA, INTERVALO, ESPERA};
  assign db_estado   = estado;

  always_comb begin
    valor_carga = '0;
    case (estado)
      MOSTRA:    valor_carga = carga(T_SHOW);
      INTERVALO: valor_carga = carga(T_GAP);
      ESPERA:    valor_carga = carga(T_TIMEOUT);
      default:   valor_carga = '0;
    endcase
  end

  temporizador_rodada u_temporizador (
    .clock  (clock),
    .reset  (reset),
    .load   (carrega),
    .enable (conta_tempo),
    .valor  (valor_carga),
    .fim    (fim_timer)
  );

  always_comb begin
    prox = estado;
    case (estado)
      INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
        if (jogar) prox = PREPARA;
      PREPARA:     prox = MOSTRA;
      MOSTRA:      if (expirou) prox = INTERVALO;
      INTERVALO:   if (expirou) prox = fim_contagem ? ESPERA : PROX_MOSTRA;
      PROX_MOSTRA: prox = MOSTRA;
      ESPERA:
        if (jogada) prox = REGISTRA;
`ifdef TIMEOUT_EN
        else if (expirou) prox = FIM_TIMEOUT;
`endif
      REGISTRA:    prox = COMPARA;
      COMPARA:
        if (!igual)             prox = FIM_PERDEU;
        else if (!fim_contagem) prox = PROX_JOGADA;
        else if (fim_rodadas)   prox = FIM_GANHOU;
        else                    prox = PROX_RODADA;
      PROX_JOGADA: prox = ESPERA;
      PROX_RODADA: prox = MOSTRA;
      default:     prox = INICIAL;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado         <= INICIAL;
      carrega        <= 1'b0;
      zera_contagem  <= 1'b0;
      conta_contagem <= 1'b0;
      zera_limite    <= 1'b0;
      conta_limite   <= 1'b0;
      registra       <= 1'b0;
      leds_en        <= 1'b0;
      pronto         <= 1'b0;
      ganhou         <= 1'b0;
      perdeu         <= 1'b0;
      timeout        <= 1'b0;
    end else begin
      estado         <= prox;
      carrega        <= (prox != estado);
      // The address clear on leaving the show phase is a one-cycle pulse
      // in the first ESPERA cycle.
      zera_contagem  <= (prox == PREPARA) || (prox == PROX_RODADA) ||
                        (estado == INTERVALO && prox == ESPERA);
      conta_contagem <= (prox == PROX_MOSTRA) || (prox == PROX_JOGADA);
      zera_limite    <= (prox == PREPARA);
      conta_limite   <= (prox == PROX_RODADA);
      registra       <= (prox == REGISTRA);
      leds_en        <= (prox == MOSTRA);
      pronto         <= prox inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
      ganhou         <= (prox == FIM_GANHOU);
      perdeu         <= (prox == FIM_PERDEU);
`ifdef TIMEOUT_EN
      timeout        <= (prox == FIM_TIMEOUT);
`else
      timeout        <= 1'b0;
`endif
    end
  end

endmodule
